mem_arbiter_resp: RTL and testbench

- Responder side of the cache/memory request interface: accepts word requests from one icache port and one dcache port and serializes them onto a single RAM port.
- Raises the per-requester wait signal until the RAM completes the access, then returns the read data and releases wait for exactly one cycle.
- Sits between the caches and RAM as the memory controller for a single CPU.

---
 rtl/mem_arbiter_resp.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_arbiter_resp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_resp.sv
// mem_arbiter_resp: memory-side responder that serializes icache and dcache
// word requests onto one RAM port. The dcache normally wins arbitration.
// The icache is granted after STARVE_LIMIT consecutive dcache grants made
// while it was waiting. An access that keeps seeing ERROR is completed with
// a poison word after ERR_RETRY_MAX attempts.
// Optional build macro: ARB_STATS_EN adds per-requester completion counters.
module mem_arbiter_resp #(
    parameter int STARVE_LIMIT  = 4,
    parameter int ERR_RETRY_MAX = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [31:0] dgrant_cnt,
    output logic [31:0] igrant_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_ACC  = 3'd1,
        ST_I_ACC  = 3'd2,
        ST_D_DONE = 3'd3,
        ST_I_DONE = 3'd4
    } state_e;

    localparam logic [1:0]  RAM_ACCESS   = 2'd2;
    localparam logic [1:0]  RAM_ERROR    = 2'd3;
    localparam logic [31:0] ERR_DATA     = 32'hBAD0BAD0;
    localparam logic [7:0]  STARVE_MAX_C = 8'(STARVE_LIMIT);
    localparam logic [7:0]  RETRY_MAX_C  = 8'(ERR_RETRY_MAX);

    state_e      state_q;
    logic [7:0]  starve_q;
    logic [7:0]  retry_q;
    logic        iwait_q;
    logic        dwait_q;
    logic [31:0] iload_q;
    logic [31:0] dload_q;

    logic        d_req_s;
    logic        grant_d_s;
    logic [7:0]  retry_inc_s;
    logic        retry_exhausted_s;
    logic        ram_ren_s;
    logic        ram_wen_s;
    logic [31:0] ram_addr_s;
    logic [31:0] ram_store_s;
    logic        addr_lsb_unused_s;

    // RAM words are always addressed aligned, so the byte-offset bits are ignored
    assign addr_lsb_unused_s = ^{daddr[1:0], iaddr[1:0]};

    assign d_req_s           = dREN | dWEN;
    // the dcache wins unless the icache has waited through STARVE_LIMIT dcache grants
    assign grant_d_s         = d_req_s & ~(iREN & (starve_q == STARVE_MAX_C));
    assign retry_inc_s       = retry_q + 8'd1;
    assign retry_exhausted_s = (retry_inc_s >= RETRY_MAX_C);

    // Arbitration FSM with registered waits and load data
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            starve_q <= 8'd0;
            retry_q  <= 8'd0;
            iwait_q  <= 1'b1;
            dwait_q  <= 1'b1;
            iload_q  <= 32'd0;
            dload_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    iwait_q <= 1'b1;
                    dwait_q <= 1'b1;
                    if (grant_d_s) begin
                        state_q <= ST_D_ACC;
                    end else if (iREN) begin
                        state_q <= ST_I_ACC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_D_ACC: begin
                    if (!d_req_s) begin
                        state_q <= ST_IDLE;
                        retry_q <= 8'd0;
                    end else if (ramstate == RAM_ACCESS) begin
                        dload_q <= ramload;
                        dwait_q <= 1'b0;
                        state_q <= ST_D_DONE;
                    end else if (ramstate == RAM_ERROR) begin
                        retry_q <= retry_inc_s;
                        if (retry_exhausted_s) begin
                            dload_q <= ERR_DATA;
                            dwait_q <= 1'b0;
                            state_q <= ST_D_DONE;
                        end else begin
                            state_q <= ST_D_ACC;
                        end
                    end else begin
                        state_q <= ST_D_ACC;
                    end
                end
                ST_I_ACC: begin
                    if (!iREN) begin
                        state_q <= ST_IDLE;
                        retry_q <= 8'd0;
                    end else if (ramstate == RAM_ACCESS) begin
                        iload_q <= ramload;
                        iwait_q <= 1'b0;
                        state_q <= ST_I_DONE;
                    end else if (ramstate == RAM_ERROR) begin
                        retry_q <= retry_inc_s;
                        if (retry_exhausted_s) begin
                            iload_q <= ERR_DATA;
                            iwait_q <= 1'b0;
                            state_q <= ST_I_DONE;
                        end else begin
                            state_q <= ST_I_ACC;
                        end
                    end else begin
                        state_q <= ST_I_ACC;
                    end
                end
                ST_D_DONE: begin
                    dwait_q <= 1'b1;
                    retry_q <= 8'd0;
                    state_q <= ST_IDLE;
                    if (!iREN) begin
                        starve_q <= 8'd0;
                    end else if (starve_q >= STARVE_MAX_C) begin
                        starve_q <= STARVE_MAX_C;
                    end else begin
                        starve_q <= starve_q + 8'd1;
                    end
                end
                ST_I_DONE: begin
                    iwait_q  <= 1'b1;
                    starve_q <= 8'd0;
                    retry_q  <= 8'd0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    iwait_q <= 1'b1;
                    dwait_q <= 1'b1;
                    retry_q <= 8'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port drive; the enables follow the live request so withdrawal and reset drop them at once
    always_comb begin
        ram_ren_s   = 1'b0;
        ram_wen_s   = 1'b0;
        ram_addr_s  = 32'd0;
        ram_store_s = 32'd0;
        if (RST) begin
            ram_ren_s = 1'b0;
        end else begin
            case (state_q)
                ST_D_ACC: begin
                    ram_addr_s = {daddr[31:2], 2'b00};
                    if (dWEN) begin
                        ram_wen_s   = 1'b1;
                        ram_store_s = dstore;
                    end else begin
                        ram_ren_s = dREN;
                    end
                end
                ST_I_ACC: begin
                    ram_addr_s = {iaddr[31:2], 2'b00};
                    ram_ren_s  = iREN;
                end
                default: begin
                    ram_ren_s = 1'b0;
                end
            endcase
        end
    end

    assign ramREN   = ram_ren_s;
    assign ramWEN   = ram_wen_s;
    assign ramaddr  = ram_addr_s;
    assign ramstore = ram_store_s;
    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign iload    = iload_q;
    assign dload    = dload_q;

`ifdef ARB_STATS_EN
    logic [31:0] dgrant_q;
    logic [31:0] igrant_q;

    // Completion counters, one step per DONE cycle, wrapping naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            dgrant_q <= 32'd0;
            igrant_q <= 32'd0;
        end else begin
            if (state_q == ST_D_DONE) begin
                dgrant_q <= dgrant_q + 32'd1;
            end else begin
                dgrant_q <= dgrant_q;
            end
            if (state_q == ST_I_DONE) begin
                igrant_q <= igrant_q + 32'd1;
            end else begin
                igrant_q <= igrant_q;
            end
        end
    end

    assign dgrant_cnt = dgrant_q;
    assign igrant_cnt = igrant_q;
`else
    assign dgrant_cnt = 32'h0;
    assign igrant_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_arbiter_resp.sv
// Bench for mem_arbiter_resp: directed cases followed by a random phase where
// the bench plays both caches and the RAM and predicts every completion.
module tb_mem_arbiter_resp;

    localparam int STARVE_LIMIT  = 4;
    localparam int ERR_RETRY_MAX = 3;
    localparam int N_RAND        = 400;
    localparam logic [1:0] R_FREE = 2'd0;
    localparam logic [1:0] R_BUSY = 2'd1;
    localparam logic [1:0] R_ACC  = 2'd2;
    localparam logic [1:0] R_ERR  = 2'd3;
    localparam logic [31:0] BAD   = 32'hBAD0BAD0;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, dgrant_cnt, igrant_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter_resp #(.STARVE_LIMIT(STARVE_LIMIT), .ERR_RETRY_MAX(ERR_RETRY_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic see();
        @(negedge CLK);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iwait"}, 32'(iwait), 32'd1);
        chk({tag, "_dwait"}, 32'(dwait), 32'd1);
        chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        chk({tag, "_ramaddr"}, ramaddr, 32'd0);
        chk({tag, "_ramstore"}, ramstore, 32'd0);
        chk({tag, "_iload"}, iload, 32'd0);
        chk({tag, "_dload"}, dload, 32'd0);
        chk({tag, "_dgrant"}, dgrant_cnt, 32'd0);
        chk({tag, "_igrant"}, igrant_cnt, 32'd0);
    endtask

    // Starts in an IDLE cycle; RAM answers ERROR for nerr cycles, then ACCESS.
    task automatic d_read(input string tag, input logic [31:0] addr, input int nerr,
                          input logic [31:0] data, input logic [31:0] exp);
        int lat;
        dREN = 1'b1; dWEN = 1'b0; daddr = addr; ramload = data;
        ramstate = (nerr > 0) ? R_ERR : R_ACC;
        lat = (nerr >= ERR_RETRY_MAX) ? ERR_RETRY_MAX + 1 : nerr + 2;
        for (int c = 1; c <= lat; c++) begin
            tick();
            ramstate = (c <= nerr) ? R_ERR : R_ACC;
            see();
            if (c == 1) begin
                chk({tag, "_ramREN"}, 32'(ramREN), 32'd1);
                chk({tag, "_ramaddr"}, ramaddr, {addr[31:2], 2'b00});
            end
            if (c < lat) begin
                chk({tag, "_wait_hi"}, 32'(dwait), 32'd1);
            end else begin
                chk({tag, "_wait_lo"}, 32'(dwait), 32'd0);
                chk({tag, "_dload"}, dload, exp);
            end
        end
        tick();
        dREN = 1'b0; ramstate = R_ACC;
        see();
        chk({tag, "_wait_after"}, 32'(dwait), 32'd1);
        tick();
    endtask

    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    logic [7:0]  seq  [15];

    initial begin
        int n;
        int idx;
        int errc;
        int sc;
        int nd;
        int ni;
        int r;
        bit d_act, i_act, d_wr, d_done_nx, i_done_nx, acc_prev;
        logic [31:0] d_a, d_wd, i_a, d_exp, i_exp;
        logic [1:0]  rs;
        logic [3:0]  region;

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = R_FREE;
        repeat (2) tick();
        see();
        chk_reset("rst");
        tick();
        RST = 1'b0;
        see();
        chk_reset("rst_rel");
        tick();

        // single dcache read, zero-wait RAM
        d_read("rd1", 32'h0000_0104, 0, 32'hCAFEF00D, 32'hCAFEF00D);

        // write wins over read, address aligned
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_3103; dstore = 32'h0000_0055; ramstate = R_ACC;
        tick();
        see();
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h0000_3100);
        chk("wr_ramstore", ramstore, 32'h0000_0055);
        tick();
        see();
        chk("wr_dwait_lo", 32'(dwait), 32'd0);
        tick();
        dREN = 1'b0; dWEN = 1'b0;
        see();
        chk("wr_dwait_hi", 32'(dwait), 32'd1);
        chk("wr_idle_wen", 32'(ramWEN), 32'd0);
        tick();

        // both requesters held: 4 dcache grants then 1 icache grant
        iREN = 1'b1; iaddr = 32'h1000_0040; dREN = 1'b1; daddr = 32'h2000_0080;
        ramload = 32'hA5A5_0001; ramstate = R_ACC;
        n = 0;
        for (int c = 0; c < 150 && n < 15; c++) begin
            see();
            chk("fair_wait_excl", 32'(dwait | iwait), 32'd1);
            if (!dwait) begin
                seq[n] = "D"; n++;
            end else if (!iwait) begin
                seq[n] = "I"; n++;
            end
            tick();
        end
        iREN = 1'b0; dREN = 1'b0;
        chk("fair_count", n, 15);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("fair_seq%0d", k), 32'(seq[k]), (k % 5 == 4) ? 32'("I") : 32'("D"));
        end
        chk("fair_iload", iload, 32'hA5A5_0001);
        tick();

        // error retries: exhausted -> poison word; fresh access starts from zero retries
        d_read("err3", 32'h2000_0200, 3, 32'h1111_1111, BAD);
        d_read("err2", 32'h2000_0204, 2, 32'h1234_5678, 32'h1234_5678);
        d_read("err1", 32'h2000_0208, 1, 32'h8765_4321, 32'h8765_4321);

        // withdrawal while RAM is busy
        dREN = 1'b1; daddr = 32'h2000_0300; ramstate = R_BUSY;
        tick();
        see();
        chk("wd_grant_ren", 32'(ramREN), 32'd1);
        tick();
        dREN = 1'b0;
        see();
        chk("wd_ren_drop", 32'(ramREN), 32'd0);
        chk("wd_wen_drop", 32'(ramWEN), 32'd0);
        chk("wd_dwait", 32'(dwait), 32'd1);
        tick();
        d_read("wd_next", 32'h2000_0304, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // reset in the middle of an access
        dREN = 1'b1; daddr = 32'h2000_0010; ramstate = R_BUSY;
        tick();
        see();
        chk("rmid_ren_pre", 32'(ramREN), 32'd1);
        tick();
        RST = 1'b1;
        see();
        chk("rmid_ren_same", 32'(ramREN), 32'd0);
        chk("rmid_dwait", 32'(dwait), 32'd1);
        tick();
        see();
        chk_reset("rmid");
        tick();
        RST = 1'b0; dREN = 1'b0;
        see();
        chk_reset("rmid_rel");
        tick();

        // random phase: bench is both caches and the RAM
        for (int k = 0; k < 16; k++) begin
            imem[k] = $urandom;
            dmem[k] = $urandom;
        end
        d_act = 1'b0; i_act = 1'b0; d_wr = 1'b0; d_done_nx = 1'b0; i_done_nx = 1'b0;
        acc_prev = 1'b0; errc = 0; sc = 0; nd = 0; ni = 0;
        d_a = 32'd0; d_wd = 32'd0; i_a = 32'd0; d_exp = 32'd0; i_exp = 32'd0;
        for (int cyc = 0; cyc < N_RAND + 25; cyc++) begin
            if (!d_act) begin
                dREN = 1'b0; dWEN = 1'b0;
                if (cyc < N_RAND && $urandom_range(2) == 0) begin
                    d_act = 1'b1;
                    d_wr  = 1'($urandom_range(1));
                    idx   = int'($urandom_range(15));
                    d_a   = 32'h2000_0000 | (32'(idx) << 2) | 32'($urandom_range(3));
                    d_wd  = $urandom;
                    dWEN  = d_wr;
                    dREN  = d_wr ? 1'($urandom_range(1)) : 1'b1;
                    daddr = d_a; dstore = d_wd;
                end
            end
            if (!i_act) begin
                iREN = 1'b0;
                if (cyc < N_RAND && $urandom_range(2) == 0) begin
                    i_act = 1'b1;
                    idx   = int'($urandom_range(15));
                    i_a   = 32'h1000_0000 | (32'(idx) << 2) | 32'($urandom_range(3));
                    iREN  = 1'b1; iaddr = i_a;
                end
            end
            see();
            chk("r_dwait", 32'(dwait), 32'(!d_done_nx));
            chk("r_iwait", 32'(iwait), 32'(!i_done_nx));
            if (d_done_nx) begin
                if (!d_wr) chk("r_dload", dload, d_exp);
                d_act = 1'b0; nd++;
                if (iREN) sc++; else sc = 0;
                chk("r_starve_bound", 32'(sc <= STARVE_LIMIT), 32'd1);
            end
            if (i_done_nx) begin
                chk("r_iload", iload, i_exp);
                i_act = 1'b0; ni++; sc = 0;
            end
            d_done_nx = 1'b0; i_done_nx = 1'b0;
            if (ramREN || ramWEN) begin
                if (!acc_prev) errc = 0;
                acc_prev = 1'b1;
                region = ramaddr[31:28];
                idx    = int'(ramaddr[5:2]);
                if (region == 4'h2) begin
                    chk("r_daddr", ramaddr, {d_a[31:2], 2'b00});
                    chk("r_dwen", 32'(ramWEN), 32'(d_wr));
                    if (d_wr) chk("r_dstore", ramstore, d_wd);
                end else begin
                    chk("r_iaddr", ramaddr, {i_a[31:2], 2'b00});
                    chk("r_iwen", 32'(ramWEN), 32'd0);
                end
                r = int'($urandom_range(99));
                if (cyc >= N_RAND) rs = R_ACC;
                else if (r < 40) rs = R_ACC;
                else if (r < 65) rs = R_BUSY;
                else if (r < 80) rs = R_FREE;
                else rs = R_ERR;
                ramstate = rs; ramload = $urandom;
                if (rs == R_ACC) begin
                    if (region == 4'h2) begin
                        if (d_wr) dmem[idx] = d_wd;
                        else begin ramload = dmem[idx]; d_exp = dmem[idx]; end
                        d_done_nx = 1'b1;
                    end else begin
                        ramload = imem[idx]; i_exp = imem[idx]; i_done_nx = 1'b1;
                    end
                end else if (rs == R_ERR) begin
                    errc++;
                    if (errc >= ERR_RETRY_MAX) begin
                        if (region == 4'h2) begin d_exp = BAD; d_done_nx = 1'b1; end
                        else begin i_exp = BAD; i_done_nx = 1'b1; end
                    end
                end
            end else begin
                acc_prev = 1'b0;
                ramstate = 2'($urandom_range(3)); ramload = $urandom;
            end
            tick();
        end
        chk("r_drain", {30'd0, d_act, i_act}, 32'd0);

`ifdef ARB_STATS_EN
        chk("stats_d", dgrant_cnt, 32'(nd));
        chk("stats_i", igrant_cnt, 32'(ni));
`else
        chk("stats_d_off", dgrant_cnt, 32'd0);
        chk("stats_i_off", igrant_cnt, 32'd0);
`endif
        RST = 1'b1;
        tick();
        see();
        chk_reset("final_rst");
        RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
